// File: rtl/vga_grayscale_transmitter_if.sv
// Pixel write bus from the Sobel/threshold stage into the VGA transmitter:
// a grayscale sample tagged with its frame coordinates and a write strobe.
interface vga_grayscale_transmitter_if #(
   parameter int P_SUBPIXEL_DEPTH    = 8,
   parameter int P_FRAME_COLUMN_BITS = 10,
   parameter int P_FRAME_ROW_BITS    = 9
);
   logic [P_SUBPIXEL_DEPTH-1:0]    I_PIXEL;
   logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN;
   logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW;
   logic                           I_PIXEL_VALID;

   modport master (output I_PIXEL, I_PIXEL_COLUMN, I_PIXEL_ROW, I_PIXEL_VALID);
   modport slave  (input  I_PIXEL, I_PIXEL_COLUMN, I_PIXEL_ROW, I_PIXEL_VALID);
endinterface

// File: rtl/vga_grayscale_transmitter.sv
// Stores processed grayscale pixels in a two-line ping-pong buffer and
// regenerates a VGA stream (syncs, data valid, gray RGB) from its own counters.
module vga_grayscale_transmitter #(
   parameter int P_FRAME_COLUMNS     = 640,
   parameter int P_FRAME_ROWS        = 480,
   parameter int P_H_FRONT_PORCH     = 16,
   parameter int P_H_SYNC            = 96,
   parameter int P_H_BACK_PORCH      = 48,
   parameter int P_V_FRONT_PORCH     = 10,
   parameter int P_V_SYNC            = 2,
   parameter int P_V_BACK_PORCH      = 33,
   parameter int P_SUBPIXEL_DEPTH    = 8,
   parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
   parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
   input  logic                          I_CLK,
   input  logic                          I_RESET,
   input  logic                          I_PIXEL_CLK_EN,
   vga_grayscale_transmitter_if.slave    pixel_in,
   output logic                          O_HSYNC,
   output logic                          O_VSYNC,
   output logic                          O_DATA_VALID,
   output logic [3*P_SUBPIXEL_DEPTH-1:0] O_PIXEL,
   output logic                          O_FRAME_START,
   output logic                          O_OUT_OF_RANGE
);
   localparam int H_TOTAL = P_FRAME_COLUMNS + P_H_FRONT_PORCH + P_H_SYNC + P_H_BACK_PORCH;
   localparam int V_TOTAL = P_FRAME_ROWS + P_V_FRONT_PORCH + P_V_SYNC + P_V_BACK_PORCH;
   localparam int H_BITS  = $clog2(H_TOTAL);
   localparam int V_BITS  = $clog2(V_TOTAL);
   localparam int IDX_BITS = $clog2(P_FRAME_COLUMNS);

   localparam logic [H_BITS-1:0] H_ACTIVE     = H_BITS'(P_FRAME_COLUMNS);
   localparam logic [H_BITS-1:0] H_SYNC_START = H_BITS'(P_FRAME_COLUMNS + P_H_FRONT_PORCH);
   localparam logic [H_BITS-1:0] H_SYNC_END   = H_BITS'(P_FRAME_COLUMNS + P_H_FRONT_PORCH + P_H_SYNC);
   localparam logic [H_BITS-1:0] H_LAST       = H_BITS'(H_TOTAL - 1);
   localparam logic [V_BITS-1:0] V_ACTIVE     = V_BITS'(P_FRAME_ROWS);
   localparam logic [V_BITS-1:0] V_SYNC_START = V_BITS'(P_FRAME_ROWS + P_V_FRONT_PORCH);
   localparam logic [V_BITS-1:0] V_SYNC_END   = V_BITS'(P_FRAME_ROWS + P_V_FRONT_PORCH + P_V_SYNC);
   localparam logic [V_BITS-1:0] V_LAST       = V_BITS'(V_TOTAL - 1);

   // One extra bit so a limit equal to 2**BITS still compares correctly.
   localparam logic [P_FRAME_COLUMN_BITS:0] COL_LIMIT = (P_FRAME_COLUMN_BITS + 1)'(P_FRAME_COLUMNS);
   localparam logic [P_FRAME_ROW_BITS:0]    ROW_LIMIT = (P_FRAME_ROW_BITS + 1)'(P_FRAME_ROWS);

   logic [H_BITS-1:0]           h_cnt;
   logic [V_BITS-1:0]           v_cnt;
   logic [P_SUBPIXEL_DEPTH-1:0] line_buf [2][P_FRAME_COLUMNS];
   logic [P_SUBPIXEL_DEPTH-1:0] rd_data;
   logic                        active;
   logic                        h_sync_on;
   logic                        v_sync_on;
   logic                        wr_in_range;
   logic                        wr_en;
   logic                        wr_oor;

   assign active    = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
   assign h_sync_on = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
   assign v_sync_on = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
   assign rd_data   = line_buf[v_cnt[0]][h_cnt[IDX_BITS-1:0]];

   assign wr_in_range = ({1'b0, pixel_in.I_PIXEL_COLUMN} < COL_LIMIT) &&
                        ({1'b0, pixel_in.I_PIXEL_ROW} < ROW_LIMIT);
   assign wr_en  = pixel_in.I_PIXEL_VALID && wr_in_range;
   assign wr_oor = pixel_in.I_PIXEL_VALID && !wr_in_range;

   // NOTE: the line buffer has no reset; a frame-sized reset fan-out buys nothing since rows are rewritten before display.
   always_ff @(posedge I_CLK) begin
      if (wr_en)
         line_buf[pixel_in.I_PIXEL_ROW[0]][pixel_in.I_PIXEL_COLUMN[IDX_BITS-1:0]] <= pixel_in.I_PIXEL;
   end

   // NOTE: non-blocking updates let O_PIXEL sample the buffer before a same-cycle write lands (old value wins).
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         h_cnt          <= '0;
         v_cnt          <= '0;
         O_HSYNC        <= 1'b1;
         O_VSYNC        <= 1'b1;
         O_DATA_VALID   <= 1'b0;
         O_PIXEL        <= '0;
         O_FRAME_START  <= 1'b0;
         O_OUT_OF_RANGE <= 1'b0;
      end else begin
         O_FRAME_START <= 1'b0;
         if (wr_oor)
            O_OUT_OF_RANGE <= 1'b1;

         if (I_PIXEL_CLK_EN) begin
            O_HSYNC       <= !h_sync_on;
            O_VSYNC       <= !v_sync_on;
            O_DATA_VALID  <= active;
            O_PIXEL       <= active ? {3{rd_data}} : '0;
            O_FRAME_START <= (h_cnt == '0) && (v_cnt == '0);

            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_vga_grayscale_transmitter.sv
// Self-checking bench for vga_grayscale_transmitter on a small 8x4 frame:
// a frame-position model checked every cycle plus directed literal checks.
module tb_vga_grayscale_transmitter;
   localparam int COLS = 8, ROWS = 4;
   localparam int HFP = 1, HS = 2, HBP = 1;
   localparam int VFP = 1, VS = 1, VBP = 1;
   localparam int DEPTH = 8, CBITS = 4, RBITS = 3;
   localparam int HT = COLS + HFP + HS + HBP;
   localparam int VT = ROWS + VFP + VS + VBP;
   localparam int FT = HT * VT;

   logic clk;
   logic rst;
   logic en;
   logic hsync, vsync, dv, fs, oor;
   logic [3*DEPTH-1:0] pix;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 0;
   bit every4 = 0;

   vga_grayscale_transmitter_if #(
      .P_SUBPIXEL_DEPTH(DEPTH), .P_FRAME_COLUMN_BITS(CBITS), .P_FRAME_ROW_BITS(RBITS)
   ) px_if ();

   vga_grayscale_transmitter #(
      .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS),
      .P_H_FRONT_PORCH(HFP), .P_H_SYNC(HS), .P_H_BACK_PORCH(HBP),
      .P_V_FRONT_PORCH(VFP), .P_V_SYNC(VS), .P_V_BACK_PORCH(VBP),
      .P_SUBPIXEL_DEPTH(DEPTH), .P_FRAME_COLUMN_BITS(CBITS), .P_FRAME_ROW_BITS(RBITS)
   ) dut (
      .I_CLK(clk), .I_RESET(rst), .I_PIXEL_CLK_EN(en),
      .pixel_in(px_if.slave),
      .O_HSYNC(hsync), .O_VSYNC(vsync), .O_DATA_VALID(dv), .O_PIXEL(pix),
      .O_FRAME_START(fs), .O_OUT_OF_RANGE(oor)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the n-th enable since reset shows frame position n mod FT.
   logic [7:0]  mbuf [2][COLS];
   logic        m_hs, m_vs, m_dv, m_fs, m_oor;
   logic [23:0] m_pix;
   int          n_en;

   initial begin
      for (int b = 0; b < 2; b++)
         for (int c = 0; c < COLS; c++)
            mbuf[b][c] = 'x;
   end

   always @(posedge clk) begin
      int p, mh, mv, wc, wr;
      if (rst) begin
         n_en = 0;
         m_hs = 1'b1; m_vs = 1'b1; m_dv = 1'b0; m_pix = '0; m_fs = 1'b0; m_oor = 1'b0;
      end else begin
         m_fs = 1'b0;
         if (en) begin
            p  = n_en % FT;
            mh = p % HT;
            mv = p / HT;
            m_dv  = (mh < COLS) && (mv < ROWS);
            m_hs  = !((mh >= COLS + HFP) && (mh < COLS + HFP + HS));
            m_vs  = !((mv >= ROWS + VFP) && (mv < ROWS + VFP + VS));
            m_pix = m_dv ? {3{mbuf[mv % 2][mh]}} : 24'h0;
            m_fs  = (p == 0);
            n_en++;
         end
      end
      if (px_if.I_PIXEL_VALID) begin
         wc = int'(px_if.I_PIXEL_COLUMN);
         wr = int'(px_if.I_PIXEL_ROW);
         if (wc < COLS && wr < ROWS) mbuf[wr % 2][wc] = px_if.I_PIXEL;
         else if (!rst)              m_oor = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("cyc_hsync", 32'(hsync), 32'(m_hs));
         check("cyc_vsync", 32'(vsync), 32'(m_vs));
         check("cyc_data_valid", 32'(dv), 32'(m_dv));
         check("cyc_frame_start", 32'(fs), 32'(m_fs));
         check("cyc_out_of_range", 32'(oor), 32'(m_oor));
         if (!$isunknown(m_pix)) check("cyc_pixel", 32'(pix), 32'(m_pix));
      end
   end

   task automatic write_px(input int col, input int row, input logic [7:0] val);
      px_if.I_PIXEL_COLUMN = CBITS'(col);
      px_if.I_PIXEL_ROW    = RBITS'(row);
      px_if.I_PIXEL        = val;
      px_if.I_PIXEL_VALID  = 1'b1;
      @(negedge clk);
      px_if.I_PIXEL_VALID  = 1'b0;
   endtask

   task automatic wait_fs(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!fs && cycles < budget);
      if (!fs) check("fs_timeout", 32'(fs), 32'd1);
   endtask

   initial begin
      int c, dv_cnt, hs_cnt, vs_cnt, fs_cnt, hs_first, vs_first, ecnt;
      rst = 1'b1;
      en  = 1'b1;
      px_if.I_PIXEL = '0; px_if.I_PIXEL_COLUMN = '0; px_if.I_PIXEL_ROW = '0; px_if.I_PIXEL_VALID = 1'b0;
      ecnt = 0;
      fork
         forever begin
            @(negedge clk);
            en = every4 ? (ecnt % 4 == 0) : 1'b1;
            ecnt++;
         end
      join_none

      repeat (3) @(negedge clk);
      cmp_on = 1;
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_data_valid", 32'(dv), 32'd0);
      check("rst_pixel", 32'(pix), 32'd0);
      check("rst_frame_start", 32'(fs), 32'd0);
      check("rst_out_of_range", 32'(oor), 32'd0);
      rst = 1'b0;

      // Frame 0: timing profile with the enable held high.
      wait_fs(200, c);
      dv_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; hs_first = -1; vs_first = -1;
      for (int i = 0; i < FT; i++) begin
         if (dv) dv_cnt++;
         if (fs) fs_cnt++;
         if (!hsync) begin hs_cnt++; if (hs_first < 0) hs_first = i; end
         if (!vsync) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
         @(negedge clk);
      end
      check("frame_period_84", 32'(fs), 32'd1);
      check("fs_once_per_frame", 32'(fs_cnt), 32'd1);
      check("dv_per_frame", 32'(dv_cnt), 32'd32);
      check("hsync_low_per_frame", 32'(hs_cnt), 32'd14);
      check("hsync_first_low", 32'(hs_first), 32'd9);
      check("vsync_low_per_frame", 32'(vs_cnt), 32'd12);
      check("vsync_first_low", 32'(vs_first), 32'd60);

      // Data path: rows 0..3 written during frame 1, shown in frame 2.
      for (int r = 0; r < ROWS; r++)
         for (int cc = 0; cc < COLS; cc++)
            write_px(cc, r, 8'(r * 16 + cc));
      wait_fs(200, c);
      repeat (8) @(negedge clk);
      check("blank_pixel", 32'(pix), 32'h0);
      repeat (21) @(negedge clk);
      check("pixel_l2_c5", 32'(pix), 32'h252525);

      // Collision on bank 0 column 3 during line 0.
      write_px(3, 0, 8'h11);
      wait_fs(200, c);
      repeat (2) @(negedge clk);
      write_px(3, 0, 8'hAA);
      check("collision_old", 32'(pix), 32'h111111);
      wait_fs(200, c);
      repeat (3) @(negedge clk);
      check("collision_new", 32'(pix), 32'hAAAAAA);

      // Out-of-range writes.
      write_px(8, 0, 8'hEE);
      check("oor_column", 32'(oor), 32'd1);
      write_px(4, 1, 8'h99);
      check("oor_sticky", 32'(oor), 32'd1);
      write_px(1, 4, 8'hEE);
      wait_fs(200, c);
      check("oor_buf_c0", 32'(pix), 32'h202020);
      @(negedge clk);
      check("oor_buf_c1", 32'(pix), 32'h212121);

      // Enable every 4th cycle.
      every4 = 1;
      wait_fs(1000, c);
      wait_fs(1000, c);
      check("frame_len_en4", 32'(c), 32'd336);
      @(negedge clk);
      check("fs_single_en4", 32'(fs), 32'd0);

      // Reset in the middle of active line 2 (counter at h=5, v=2).
      every4 = 0;
      wait_fs(1000, c);
      repeat (28) @(negedge clk);
      check("pre_rst_dv", 32'(dv), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_hsync", 32'(hsync), 32'd1);
      check("midrst_vsync", 32'(vsync), 32'd1);
      check("midrst_data_valid", 32'(dv), 32'd0);
      check("midrst_pixel", 32'(pix), 32'd0);
      check("midrst_out_of_range", 32'(oor), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_fs", 32'(fs), 32'd1);
      check("post_rst_dv", 32'(dv), 32'd1);

      repeat (20) @(negedge clk);
      cmp_on = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_grayscale_transmitter.md
Name: vga_grayscale_transmitter

Overview:
- Output end of the edge-detection datapath: accepts processed 8-bit grayscale pixels tagged with column/row, stores them in a two-line ping-pong buffer, and regenerates a standard VGA stream (HSYNC, VSYNC, DATA_VALID, 24-bit RGB) from its own timing counters.
- Sits after the Sobel/threshold stage and drives the board's VGA output.
- Single clock domain; the pixel rate is set by a clock-enable strobe.

Parameters:
- P_FRAME_COLUMNS, 640, active columns per line
- P_FRAME_ROWS, 480, active rows per frame
- P_H_FRONT_PORCH, 16, horizontal front porch in pixels
- P_H_SYNC, 96, HSYNC pulse width in pixels
- P_H_BACK_PORCH, 48, horizontal back porch in pixels
- P_V_FRONT_PORCH, 10, vertical front porch in lines
- P_V_SYNC, 2, VSYNC pulse width in lines
- P_V_BACK_PORCH, 33, vertical back porch in lines
- P_SUBPIXEL_DEPTH, 8, grayscale input width
- P_FRAME_COLUMN_BITS, $clog2(P_FRAME_COLUMNS), column index width
- P_FRAME_ROW_BITS, $clog2(P_FRAME_ROWS), row index width

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  reset; synchronous, active-high, sampled on I_CLK
- I_PIXEL_CLK_EN  in  1  one-cycle pixel-rate strobe; all timing advances only when it is 1
- I_PIXEL  in  P_SUBPIXEL_DEPTH  processed grayscale pixel to store
- I_PIXEL_COLUMN  in  P_FRAME_COLUMN_BITS  target column of I_PIXEL
- I_PIXEL_ROW  in  P_FRAME_ROW_BITS  target row of I_PIXEL
- I_PIXEL_VALID  in  1  write strobe for I_PIXEL
- O_HSYNC  out  1  horizontal sync, active-low
- O_VSYNC  out  1  vertical sync, active-low
- O_DATA_VALID  out  1  high during the active region
- O_PIXEL  out  3*P_SUBPIXEL_DEPTH  RGB output {gray, gray, gray}
- O_FRAME_START  out  1  one I_CLK pulse at the start of each frame
- O_OUT_OF_RANGE  out  1  sticky flag: a write was addressed outside the frame

Behaviour:
- H_TOTAL = COLS + HFP + HS + HBP; V_TOTAL = ROWS + VFP + VS + VBP.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance only on cycles with I_PIXEL_CLK_EN=1.
  - h wraps to 0 after H_TOTAL-1.
  - v increments when h wraps, and wraps to 0 after V_TOTAL-1.
- Active region: h < COLS and v < ROWS.
- HSYNC is low for h in [COLS+HFP, COLS+HFP+HS).
- VSYNC is low for v in [ROWS+VFP, ROWS+VFP+VS); VSYNC is evaluated per line, using the registered v.
- Output registers (O_HSYNC, O_VSYNC, O_DATA_VALID, O_PIXEL) load on each enable cycle from the current (h, v) before the counters advance.
  - Latency is one pixel-enable from the counter state to the outputs.
  - All outputs hold their value between enables.
- O_PIXEL:
  - Active region: {buf[v[0]][h], buf[v[0]][h], buf[v[0]][h]}. The buffer read is combinational and captured in the output register.
  - Otherwise: all zeros.
- Line buffer: two banks of COLS x P_SUBPIXEL_DEPTH registers.
  - A write with I_PIXEL_VALID=1, I_PIXEL_COLUMN<COLS and I_PIXEL_ROW<ROWS stores I_PIXEL at bank I_PIXEL_ROW[0], index I_PIXEL_COLUMN.
  - Writes occur on any I_CLK cycle, independent of I_PIXEL_CLK_EN.
- Read/write collision (same bank and index in the same cycle): the output register captures the OLD stored value; the new value is visible on the next read.
- Upstream is responsible for completing row r before display line r begins. The block performs no flow control and never stalls. Stale data from row r-2 is displayed if a row is late.
- Out-of-range write (valid, with column>=COLS or row>=ROWS):
  - The buffer is unchanged.
  - O_OUT_OF_RANGE is set and stays 1 until reset.
- O_FRAME_START is 1 for exactly one I_CLK cycle: the enable cycle in which the output registers load the (h=0, v=0) state.
- Reset values:
  - h=0, v=0.
  - O_HSYNC=1, O_VSYNC=1, O_DATA_VALID=0, O_PIXEL=0.
  - O_FRAME_START=0, O_OUT_OF_RANGE=0.
  - Buffer contents are not cleared (undefined until written).
- Reset asserted mid-frame: the same values apply on the next I_CLK edge, regardless of I_PIXEL_CLK_EN. Timing restarts at (0,0) on the first enable after reset is released, and that enable pulses O_FRAME_START.
- I_PIXEL_CLK_EN held high continuously is legal (pixel rate equals I_CLK).

Test Plan:
- Timing check with COLS=8, ROWS=4, HFP=1, HS=2, HBP=1, VFP=1, VS=1, VBP=1 (H_TOTAL=12, V_TOTAL=7) and the enable held high:
  - Per line: DATA_VALID high for 8 enables, then low for 4.
  - Per line: HSYNC low for exactly 2 enables, starting at the 10th enable of the line.
  - Per frame: VSYNC low for 12 enables on line 5 (0-indexed).
  - O_FRAME_START pulses every 84 enables.
- Data path: write rows 0..3 with pixel = row*16+col before frame 2 -> in frame 2, line 2 column 5 outputs O_PIXEL=0x252525, and all blanking outputs are 0x000000.
- Enable every 4th cycle:
  - Outputs change only one cycle after each enable.
  - Frame length is 336 I_CLK cycles.
  - O_FRAME_START stays a single-cycle pulse.
- Collision: write 0xAA to bank 0, column 3, in the same cycle the active line 0 reads column 3 (previous value 0x11) -> O_PIXEL=0x111111 on that line; the next frame shows 0xAAAAAA.
- Out-of-range:
  - A write with column=8 or row=4 leaves the buffer unchanged and sets O_OUT_OF_RANGE=1, which stays 1 after further valid writes.
  - Reset clears O_OUT_OF_RANGE to 0.
- Reset mid-active-line (h=5, v=2):
  - Next cycle: HSYNC=1, VSYNC=1, DATA_VALID=0, PIXEL=0.
  - First enable after release gives O_FRAME_START=1 and DATA_VALID=1 for (0,0).
